// File: rtl/cpu_cpu_nios_cpu_debug_cmd_sync.sv
// Sysclk-side command receiver for the Nios II JTAG debug slave: synchronises the
// update-IR/DR strobes, captures IR/DR and queues commands for a valid/ready consumer.
module cpu_cpu_nios_cpu_debug_cmd_sync #(
    parameter int DR_W        = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    localparam int NCH        = 2 ** IR_W,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            vs_uir,
    input  logic            vs_udr,
    input  logic [IR_W-1:0] ir_in,
    input  logic [DR_W-1:0] sr,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic [IR_W-1:0] cmd_ir,
    output logic [DR_W-1:0] jdo,
    output logic [NCH-1:0]  take_action,
    output logic [NCH-1:0]  take_no_action,
    output logic [AW:0]     level,
    output logic            overflow,
    input  logic            clr_overflow
);

    logic [SYNC_STAGES-1:0] uir_sync;
    logic [SYNC_STAGES-1:0] udr_sync;
    logic                   uir_hist;
    logic                   udr_hist;
    logic                   uir_rise;
    logic                   udr_rise;
    logic [IR_W-1:0]        ir_q;

    logic [IR_W+DR_W-1:0]   mem [DEPTH];
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic [AW-1:0]          head_idx;
    logic                   full;
    logic                   pop;
    logic                   push_ok;
    logic                   drop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync <= '0;
            udr_sync <= '0;
            uir_hist <= 1'b0;
            udr_hist <= 1'b0;
            ir_q     <= '0;
        end else begin
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_hist <= uir_sync[SYNC_STAGES-1];
            udr_hist <= udr_sync[SYNC_STAGES-1];
            if (uir_rise) begin
                ir_q <= ir_in;
            end
        end
    end

    assign uir_rise = uir_sync[SYNC_STAGES-1] & ~uir_hist;
    assign udr_rise = udr_sync[SYNC_STAGES-1] & ~udr_hist;

    assign level     = wr_ptr - rd_ptr;
    assign cmd_valid = (level != '0);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = cmd_valid & cmd_ready;
    assign push_ok   = udr_rise & (~full | pop);
    assign drop      = udr_rise & full & ~pop;

    // While empty the slot behind the read pointer still holds the last popped
    // entry and cannot be overwritten until something is pushed.
    assign head_idx          = cmd_valid ? rd_ptr[AW-1:0] : rd_ptr[AW-1:0] - AW'(1);
    assign {cmd_ir, jdo}     = mem[head_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= {ir_q, sr};
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        take_action    = '0;
        take_no_action = '0;
        for (int k = 0; k < NCH; k++) begin
            if (pop && (cmd_ir == IR_W'(k))) begin
                take_action[k]    = jdo[DR_W-1];
                take_no_action[k] = ~jdo[DR_W-1];
            end
        end
    end

endmodule

// File: doc/cpu_cpu_nios_cpu_debug_cmd_sync.md
# cpu_cpu_nios_cpu_debug_cmd_sync

Parametrised sysclk-domain command receiver for the Nios II JTAG debug slave. It synchronises the virtual-JTAG update strobes (`vs_uir`, `vs_udr`) from the TCK domain into `clk`, and captures the instruction and data registers. Captured commands are queued in a small FIFO so that back-to-back debugger updates are not lost while the core is busy. Each command is delivered with a valid/ready handshake and per-instruction take_action / take_no_action pulses, in place of the fixed 2-bit-IR, unbuffered sysclk decoder.

## Interface
- `DR_W`, 38, width of the captured data register (`sr` / `jdo`); `jdo[DR_W-1]` is the action bit
- `IR_W`, 2, virtual IR width; `NCH = 2**IR_W` command channels
- `SYNC_STAGES`, 2, synchroniser flops per strobe (legal ≥2)
- `DEPTH`, 4, command FIFO depth (power of two, ≥2)

Ports:
- `clk`  in  1  system clock; the only clock
- `reset_n`  in  1  asynchronous, active-low reset
- `vs_uir`  in  1  update-IR level from the TCK domain (asynchronous)
- `vs_udr`  in  1  update-DR level from the TCK domain (asynchronous)
- `ir_in`  in  IR_W  virtual IR value; stable while `vs_uir` is high
- `sr`  in  DR_W  TCK-side shift register; stable for ≥SYNC_STAGES+2 clk after `vs_udr` rises
- `cmd_valid`  out  1  FIFO head holds a command
- `cmd_ready`  in  1  consumer accepts the head this cycle
- `cmd_ir`  out  IR_W  IR of the head command
- `jdo`  out  DR_W  data of the head command
- `take_action`  out  NCH  one-hot pop pulse, action bit = 1
- `take_no_action`  out  NCH  one-hot pop pulse, action bit = 0
- `level`  out  clog2(DEPTH)+1  FIFO occupancy
- `overflow`  out  1  sticky: a command was dropped
- `clr_overflow`  in  1  clears `overflow`

## Operation
- Each strobe passes through its own SYNC_STAGES-flop chain plus a history flop. `uir_rise` / `udr_rise` = last sync stage & ~history.
- On `uir_rise`: `ir_q <= ir_in`.
- On `udr_rise`: push `{ir_q, sr}` into the FIFO. The pushed IR is the `ir_q` value before any same-cycle `uir_rise` update.
- FIFO: registered storage, write/read pointers of clog2(DEPTH)+1 bits, with no empty bypass. Full = pointers differ only in the MSB.
- `pop = cmd_valid & cmd_ready`. `cmd_valid = (level != 0)`. `cmd_ir` and `jdo` show the head entry and hold their value while it is not popped; when empty they hold the last popped entry (0 after reset).
- `take_action[k] = pop & (cmd_ir == k) & jdo[DR_W-1]`.
- `take_no_action[k] = pop & (cmd_ir == k) & ~jdo[DR_W-1]`.
- These pulses are combinational from registered state and `cmd_ready`. They are high for exactly one cycle per popped command, and at most one bit of the two vectors is set.
- Push while full and no pop: command dropped, `overflow <= 1`, pointers unchanged.
- Push while full with a pop in the same cycle: both happen, no overflow, `level` unchanged.
- Push and pop while not full: both happen, `level` unchanged.
- `clr_overflow` clears `overflow` next cycle. A same-cycle drop wins and `overflow` stays 1.

## Timing
- Reset state: all synchroniser and history flops 0, `ir_q` = 0, FIFO empty, `cmd_valid` = 0, `cmd_ir` = 0, `jdo` = 0, `take_action` = 0, `take_no_action` = 0, `level` = 0, `overflow` = 0.
- A strobe level that is high at reset release yields one rise, giving one command or IR capture.
- Latency: `vs_udr` rises before clk edge 1 → `udr_rise` is high in the cycle after edge SYNC_STAGES → push at edge SYNC_STAGES+1 → `cmd_valid` = 1 after edge SYNC_STAGES+1. This is 3 edges with the defaults.
- `ir_q` is updated at edge SYNC_STAGES+1 after `vs_uir` rises.
- Pop takes effect at the clk edge ending the cycle in which the pulse was high. The next entry appears on the following cycle.
- A strobe high for less than one clk period may be missed. The TCK-side protocol keeps UIR/UDR pulses at least 1 clk + setup wide and spaced at least 2 clk apart.
- Reset asserted mid-operation: the FIFO and all queued commands are discarded at once, and the outputs return to their reset values asynchronously.

## Test plan
- Single command: IR pulse with `ir_in`=2, then UDR pulse with `sr`=38'h20_0000_1234, `cmd_ready`=1 → `cmd_valid` after 3 edges, `cmd_ir`=2, `jdo`=38'h20_0000_1234, `take_action`=4'b0100 for 1 cycle, `take_no_action`=0.
- Action bit clear: `ir_in`=1, `sr`=38'h00_DEAD_BEEF → `take_no_action`=4'b0010 on pop; `take_action` stays 0.
- Buffering/order: `cmd_ready`=0, 4 UDR pulses carrying `sr`=1,2,3,4 → `level`=4, `overflow`=0. A 5th pulse → `overflow`=1, `level`=4. Raise `cmd_ready` → pops in order 1,2,3,4, then `cmd_valid`=0.
- Full + simultaneous pop: FIFO full, `cmd_ready`=1 in the same cycle as `udr_rise` → new entry accepted, `overflow` stays 0, `level` stays 4.
- Overflow clear race: `clr_overflow`=1 in the same cycle as a drop → `overflow`=1. `clr_overflow` alone → `overflow`=0 next cycle.
- Reset mid-queue: 3 entries queued, pulse `reset_n` low → `level`=0, `cmd_valid`=0, `jdo`=0 immediately. The next UDR pulse is delivered normally.
